// File: rtl/exa_crosb_input_vc_requester_if.sv
// Request/grant/cts/last bus between one input port's descriptor path and the
// crossbar output arbiter. The master side is the input VC requester.
interface exa_crosb_input_vc_requester_if #(
    parameter int vc_num    = 3,
    parameter int prio_num  = 2,
    parameter int len_width = 8
);
    localparam int C  = vc_num * prio_num;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    // descriptor enqueue path
    logic                 i_pkt_valid;
    logic [CW-1:0]        i_pkt_class;
    logic [len_width-1:0] i_pkt_len;
    logic                 o_pkt_ready;

    // arbiter request/grant/cts path
    logic [C-1:0]         o_request;
    logic                 i_grant;
    logic [C-1:0]         i_grant_class;
    logic                 i_cts;

    // beat stream
    logic                 o_valid;
    logic [CW-1:0]        o_class;
    logic [len_width-1:0] o_beat_idx;
    logic                 o_last;
    logic                 o_err;

    modport master (
        input  i_pkt_valid, i_pkt_class, i_pkt_len, i_grant, i_grant_class, i_cts,
        output o_pkt_ready, o_request, o_valid, o_class, o_beat_idx, o_last, o_err
    );

    modport slave (
        output i_pkt_valid, i_pkt_class, i_pkt_len, i_grant, i_grant_class, i_cts,
        input  o_pkt_ready, o_request, o_valid, o_class, o_beat_idx, o_last, o_err
    );
endinterface

// File: rtl/exa_crosb_input_vc_requester.sv
// Input-side VC requester: per-class descriptor FIFOs (class = prio*vc_num+vc)
// raise requests toward the output arbiter; a granted packet is streamed one
// beat per cts cycle, with last on the final beat.
module exa_crosb_input_vc_requester #(
    parameter int vc_num    = 3,
    parameter int prio_num  = 2,
    parameter int len_width = 8,
    parameter int q_depth   = 4
) (
    input  logic clk,
    input  logic reset,
    exa_crosb_input_vc_requester_if.master bus
);
    localparam int C  = vc_num * prio_num;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    // storage is sized to the full class-index range so any i_pkt_class value indexes safely
    localparam int CN = 1 << CW;
    localparam int PW = (q_depth > 1) ? $clog2(q_depth) : 1;
    localparam int OW = $clog2(q_depth) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [len_width-1:0] mem_q    [CN][q_depth];
    logic [len_width-1:0] mem_d    [CN][q_depth];
    logic [PW-1:0]        wr_ptr_q [CN];
    logic [PW-1:0]        wr_ptr_d [CN];
    logic [PW-1:0]        rd_ptr_q [CN];
    logic [PW-1:0]        rd_ptr_d [CN];
    logic [OW-1:0]        occ_q    [CN];
    logic [OW-1:0]        occ_d    [CN];

    state_t               state_q, state_d;
    logic [CW-1:0]        cls_q, cls_d;
    logic [len_width-1:0] cnt_q, cnt_d;
    logic [len_width-1:0] len_m1_q, len_m1_d;
    logic                 err_q, err_d;

    logic [CN-1:0]        nonempty_s;
    logic                 pkt_ready_s;
    logic                 enq_s;
    logic                 gnt_onehot_s;
    logic                 gnt_req_s;
    logic [CW-1:0]        gnt_idx_s;
    logic                 acc_s;
    logic                 bad_s;
    logic [len_width-1:0] head_len_s;
    logic                 beat_s;
    logic                 last_s;

    // Decode queue status, enqueue acceptance and grant legality.
    always_comb begin
        nonempty_s = '0;
        for (int k = 0; k < CN; k++) begin
            nonempty_s[k] = (occ_q[k] != '0);
        end

        if (int'(bus.i_pkt_class) < C) begin
            pkt_ready_s = (occ_q[bus.i_pkt_class] != OW'(q_depth));
        end else begin
            pkt_ready_s = 1'b0;
        end
        enq_s = bus.i_pkt_valid && pkt_ready_s;

        gnt_onehot_s = (bus.i_grant_class != '0) &&
                       ((bus.i_grant_class & (bus.i_grant_class - C'(1))) == '0);
        gnt_req_s    = ((bus.i_grant_class & nonempty_s[C-1:0]) != '0);

        gnt_idx_s = '0;
        for (int k = 0; k < C; k++) begin
            if (bus.i_grant_class[k]) begin
                gnt_idx_s = CW'(k);
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end

        acc_s      = (state_q == ST_IDLE) && bus.i_grant && gnt_onehot_s && gnt_req_s;
        bad_s      = (state_q == ST_IDLE) && bus.i_grant && !(gnt_onehot_s && gnt_req_s);
        head_len_s = mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];

        beat_s = (state_q == ST_SEND) && bus.i_cts;
        last_s = beat_s && (cnt_q == len_m1_q);
    end

    // Output drive: requests only while idle, beats follow cts while sending.
    always_comb begin
        bus.o_pkt_ready = pkt_ready_s;
        if (state_q == ST_IDLE) begin
            bus.o_request = nonempty_s[C-1:0];
        end else begin
            bus.o_request = '0;
        end
        bus.o_valid    = beat_s;
        bus.o_last     = last_s;
        bus.o_class    = cls_q;
        bus.o_beat_idx = cnt_q;
        bus.o_err      = err_q;
    end

    // Next-state: queue push/pop, occupancy, and the IDLE/SEND packet sequencer.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        state_d  = state_q;
        cls_d    = cls_q;
        cnt_d    = cnt_q;
        len_m1_d = len_m1_q;
        err_d    = bad_s;

        if (enq_s) begin
            mem_d[bus.i_pkt_class][wr_ptr_q[bus.i_pkt_class]] = bus.i_pkt_len;
            wr_ptr_d[bus.i_pkt_class] = wr_ptr_q[bus.i_pkt_class] + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (acc_s) begin
            rd_ptr_d[gnt_idx_s] = rd_ptr_q[gnt_idx_s] + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // a same-class push and pop in one cycle leave occupancy unchanged
        for (int k = 0; k < CN; k++) begin
            case ({enq_s && (int'(bus.i_pkt_class) == k), acc_s && (int'(gnt_idx_s) == k)})
                2'b10:   occ_d[k] = occ_q[k] + OW'(1);
                2'b01:   occ_d[k] = occ_q[k] - OW'(1);
                default: occ_d[k] = occ_q[k];
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    state_d  = ST_SEND;
                    cls_d    = gnt_idx_s;
                    cnt_d    = '0;
                    len_m1_d = (head_len_s == '0) ? '0 : head_len_s - len_width'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (beat_s) begin
                    cnt_d = cnt_q + len_width'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and queue pointers; reset discards every queued descriptor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cls_q    <= '0;
            cnt_q    <= '0;
            len_m1_q <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < CN; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            len_m1_q <= len_m1_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Descriptor storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_exa_crosb_input_vc_requester.sv
// Directed bench for exa_crosb_input_vc_requester with hand-computed expectations.
module tb_exa_crosb_input_vc_requester;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   last_cnt;
    int   snap;

    exa_crosb_input_vc_requester_if bus ();

    exa_crosb_input_vc_requester dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count every emitted last beat, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.o_last === 1'b1) last_cnt = last_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int cls, input int len);
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt_class = 3'(cls);
        bus.i_pkt_len   = 8'(len);
        tick();
        bus.i_pkt_valid = 1'b0;
    endtask

    // grant one class with cts held high and check every beat of the packet
    task automatic run_pkt(input int cls, input int nbeats);
        bus.i_grant       = 1'b1;
        bus.i_grant_class = 6'b000001 << cls;
        bus.i_cts         = 1'b1;
        tick();
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        for (int b = 0; b < nbeats; b++) begin
            #1;
            check_eq("beat_valid", 32'(bus.o_valid), 32'd1);
            check_eq("beat_idx", 32'(bus.o_beat_idx), 32'(b));
            check_eq("beat_last", 32'(bus.o_last), (b == nbeats - 1) ? 32'd1 : 32'd0);
            check_eq("beat_class", 32'(bus.o_class), 32'(cls));
            check_eq("req_in_send", 32'(bus.o_request), 32'd0);
            tick();
        end
        bus.i_cts = 1'b0;
        #1;
        check_eq("post_pkt_valid", 32'(bus.o_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] cts_pat;
        int         exp_idx;
        total    = 0;
        bad      = 0;
        last_cnt = 0;
        bus.i_pkt_valid   = 1'b0;
        bus.i_pkt_class   = 3'd0;
        bus.i_pkt_len     = 8'd0;
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        bus.i_cts         = 1'b0;
        reset             = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst_request", 32'(bus.o_request), 32'd0);
        check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst_last", 32'(bus.o_last), 32'd0);
        check_eq("rst_err", 32'(bus.o_err), 32'd0);
        check_eq("rst_class", 32'(bus.o_class), 32'd0);
        check_eq("rst_beat_idx", 32'(bus.o_beat_idx), 32'd0);
        check_eq("rst_pkt_ready", 32'(bus.o_pkt_ready), 32'd1);
        reset = 1'b0;
        tick();

        // class 4, length 3
        enq(4, 3);
        #1;
        check_eq("req_c4", 32'(bus.o_request), 32'b010000);
        run_pkt(4, 3);
        check_eq("req_after_c4", 32'(bus.o_request), 32'd0);

        // zero-length packet is one beat; class 5 still pending afterwards
        enq(0, 0);
        enq(5, 2);
        #1;
        check_eq("req_c0_c5", 32'(bus.o_request), 32'b100001);
        run_pkt(0, 1);
        check_eq("req_after_c0", 32'(bus.o_request), 32'b100000);
        run_pkt(5, 2);

        // fill class 2, then a fifth enqueue coinciding with a pop is dropped
        enq(2, 1);
        enq(2, 2);
        enq(2, 3);
        enq(2, 4);
        bus.i_pkt_class = 3'd2;
        #1;
        check_eq("full_ready_c2", 32'(bus.o_pkt_ready), 32'd0);
        bus.i_pkt_class = 3'd3;
        #1;
        check_eq("ready_c3", 32'(bus.o_pkt_ready), 32'd1);
        bus.i_pkt_valid   = 1'b1;
        bus.i_pkt_class   = 3'd2;
        bus.i_pkt_len     = 8'd9;
        bus.i_grant       = 1'b1;
        bus.i_grant_class = 6'b000100;
        bus.i_cts         = 1'b0;
        #1;
        check_eq("full_pop_ready", 32'(bus.o_pkt_ready), 32'd0);
        tick();
        bus.i_pkt_valid   = 1'b0;
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        bus.i_cts         = 1'b1;
        #1;
        check_eq("c2_p1_valid", 32'(bus.o_valid), 32'd1);
        check_eq("c2_p1_last", 32'(bus.o_last), 32'd1);
        tick();
        bus.i_cts = 1'b0;
        run_pkt(2, 2);
        run_pkt(2, 3);
        run_pkt(2, 4);
        check_eq("c2_drained", 32'(bus.o_request), 32'd0);
        // pointers have wrapped; a second round must read back in order
        enq(2, 5);
        enq(2, 1);
        enq(2, 2);
        enq(2, 3);
        run_pkt(2, 5);
        run_pkt(2, 1);
        run_pkt(2, 2);
        run_pkt(2, 3);
        check_eq("c2_wrap_drained", 32'(bus.o_request), 32'd0);

        // illegal grants: multi-hot, not requested, zero
        enq(1, 2);
        bus.i_cts = 1'b1;
        for (int g = 0; g < 3; g++) begin
            bus.i_grant       = 1'b1;
            bus.i_grant_class = (g == 0) ? 6'b000011 : ((g == 1) ? 6'b001000 : 6'b000000);
            tick();
            bus.i_grant       = 1'b0;
            bus.i_grant_class = 6'b000000;
            #1;
            check_eq("bad_gnt_err", 32'(bus.o_err), 32'd1);
            check_eq("bad_gnt_valid", 32'(bus.o_valid), 32'd0);
            check_eq("bad_gnt_req", 32'(bus.o_request), 32'b000010);
            tick();
            #1;
            check_eq("bad_gnt_err_clr", 32'(bus.o_err), 32'd0);
        end
        run_pkt(1, 2);
        check_eq("c1_single_pkt", 32'(bus.o_request), 32'd0);

        // cts stalls on a 5-beat packet; grants during SEND are ignored
        enq(3, 5);
        bus.i_grant       = 1'b1;
        bus.i_grant_class = 6'b001000;
        bus.i_cts         = 1'b0;
        tick();
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        cts_pat = 8'b11011001;
        exp_idx = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_cts         = cts_pat[i];
            bus.i_grant       = ~cts_pat[i];
            bus.i_grant_class = 6'b000011;
            #1;
            check_eq("stall_valid", 32'(bus.o_valid), 32'(cts_pat[i]));
            check_eq("stall_idx", 32'(bus.o_beat_idx), 32'(exp_idx));
            check_eq("stall_last", 32'(bus.o_last), (cts_pat[i] && exp_idx == 4) ? 32'd1 : 32'd0);
            check_eq("stall_no_err", 32'(bus.o_err), 32'd0);
            if (cts_pat[i]) exp_idx = exp_idx + 1;
            tick();
        end
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        bus.i_cts         = 1'b0;
        #1;
        check_eq("stall_done_valid", 32'(bus.o_valid), 32'd0);
        check_eq("stall_done_err", 32'(bus.o_err), 32'd0);
        check_eq("stall_done_req", 32'(bus.o_request), 32'd0);

        // reset in the middle of an 8-beat packet
        enq(5, 8);
        enq(0, 2);
        bus.i_grant       = 1'b1;
        bus.i_grant_class = 6'b100000;
        bus.i_cts         = 1'b1;
        tick();
        bus.i_grant       = 1'b0;
        bus.i_grant_class = 6'b000000;
        tick();
        tick();
        #1;
        check_eq("pre_rst_idx", 32'(bus.o_beat_idx), 32'd2);
        snap  = last_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("mid_rst_req", 32'(bus.o_request), 32'd0);
        tick();
        tick();
        #1;
        check_eq("mid_rst_empty", 32'(bus.o_request), 32'd0);
        check_eq("mid_rst_no_last", 32'(last_cnt), 32'(snap));
        bus.i_pkt_class = 3'd5;
        #1;
        check_eq("mid_rst_ready", 32'(bus.o_pkt_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exa_crosb_input_vc_requester.md
Name: exa_crosb_input_vc_requester

Overview:
- Input-side counterpart of the crossbar output arbiter with virtual channels.
- Per-class descriptor queues, one class per (vc, prio) pair, holding packet lengths for one input port.
- Raises a per-class request vector toward the output arbiter. On grant, streams the granted packet beat-by-beat under arbiter cts and drives last on the final beat.
- Sits between the input buffer's descriptor path and the output arbiter's request/grant/cts/last interface.

Parameters:
- vc_num, 3, virtual channels per priority.
- prio_num, 2, priority levels; class count C = vc_num*prio_num.
- len_width, 8, packet length field width in beats.
- q_depth, 4, descriptor slots per class (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- i_pkt_valid  in  1  descriptor enqueue strobe.
- i_pkt_class  in  $clog2(C)  target class, index = prio*vc_num + vc.
- i_pkt_len  in  len_width  packet length in beats; 0 is treated as 1.
- o_pkt_ready  out  1  target class queue not full (combinational on i_pkt_class).
- o_request  out  C  per-class request, bit k = class k queue non-empty.
- i_grant  in  1  this input granted by the output arbiter.
- i_grant_class  in  C  one-hot class being granted.
- i_cts  in  1  arbiter clear-to-send; one beat is accepted per cycle it is high.
- o_valid  out  1  beat valid.
- o_class  out  $clog2(C)  class of the current packet.
- o_beat_idx  out  len_width  beat index within the packet, starting at 0.
- o_last  out  1  final beat of the packet (to arbiter i_last).
- o_err  out  1  one-cycle pulse on an illegal grant.

Behaviour:
- Reset: all queues empty, FSM=IDLE. o_request=0, o_valid=0, o_last=0, o_err=0, o_class=0, o_beat_idx=0, o_pkt_ready=1.
- Reset asserted mid-packet aborts the packet: no o_last is emitted and all queued descriptors are discarded.
- Enqueue: a descriptor is written when i_pkt_valid && o_pkt_ready. The corresponding request bit rises on the next cycle.
- Enqueue into a full queue is dropped; the source must respect o_pkt_ready.
- FSM IDLE: o_request = non-empty mask.
- Grant acceptance in IDLE: i_grant=1 and i_grant_class one-hot and that class's request bit set.
  - Latch the class.
  - Pop the queue head and latch len_m1 = max(len,1)-1.
  - beat counter=0; go SEND.
- Illegal grant: i_grant=1 with i_grant_class zero, multi-hot, or not requested. Pulse o_err next cycle, stay IDLE, pop nothing.
- FSM SEND:
  - o_request=0 for all classes (requests withdrawn while transmitting).
  - o_valid = i_cts, o_class = latched class, o_beat_idx = counter.
  - Counter increments only on cycles with i_cts=1.
  - o_last = o_valid && counter==len_m1.
  - Cycle after o_last: counter cleared, back to IDLE; requests re-evaluated that cycle.
  - i_grant in SEND is ignored, with no o_err.
- Latency:
  - Grant accepted at cycle N: first beat possible at N+1 (if i_cts).
  - Last beat at cycle M: o_request valid again at M+1.
- Simultaneous enqueue and pop on the same class in the same cycle are both performed; occupancy is unchanged.
- Full queue plus simultaneous pop: o_pkt_ready stays low that cycle (ready derived from registered occupancy).
- Pointers wrap modulo q_depth; occupancy counter is $clog2(q_depth)+1 bits.
- Single-beat packets (len 0 or 1): o_valid and o_last are asserted on the same beat.
- i_cts low in SEND stalls: o_valid=0 and counter held.

Test Plan:
- Reset then enqueue class 4 len 3 -> o_request=6'b010000 next cycle. Grant class 4 with cts held high -> o_valid for 3 cycles, o_beat_idx 0,1,2, o_last on idx 2, o_request=0 during SEND.
- Enqueue class 0 len 0 and class 5 len 2, grant class 0 -> single beat with o_last=1 at idx 0. Next cycle o_request=6'b100000.
- Fill class 2 with 4 descriptors -> o_pkt_ready=0 for class 2; 5th enqueue dropped. Grant/drain all four -> four packets, then o_request[2]=0. Pointer wrap verified by 4 further enqueues.
- Grant with i_grant_class=6'b000011 or a non-requested class -> o_err pulse, FSM stays IDLE, queue occupancy unchanged.
- Packet len 5, i_cts toggled 1,0,0,1,1,0,1,1 -> beats idx 0..4 only on cts cycles, o_last at idx 4, no beat while cts=0.
- Reset asserted at beat 2 of a len-8 packet -> next cycle o_valid=0, o_request=0, queues empty, no o_last.
